instr_fetch_unit: RTL



---
 rtl/mem_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Types and constants shared by the memory wrapper and the instruction fetch unit.
package mem_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] IMEM_LIMIT_DEFAULT = 32'h0000_6000;
    localparam int unsigned BYTE_OFFSET_W      = 2;
    localparam logic [31:0] PC_STEP            = 32'd4;

    // A PC may be fetched only if word-aligned and inside instruction space.
    function automatic logic pc_fetchable(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[BYTE_OFFSET_W-1:0] == '0) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead synchronous FIFO of {pc, instr} entries with flush and occupancy count.
module fetch_queue
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: one outstanding memory request, redirect/drain handling,
// fault halt on bad PCs, and a show-ahead {pc, instr} queue toward decode.
module instr_fetch_unit
    import mem_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] IMEM_LIMIT  = IMEM_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        memValid1,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    input  logic        INSTR_READY,
    output logic        FAULT
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t     state_q;
    logic [31:0]      fetch_pc_q, fetch_pc_d, req_pc_q;
    logic             rden_q, discard_q;
    logic             complete, push, pop, still_outstanding, q_full, q_empty;
    logic [CNT_W-1:0] q_count, count_next;
    fetch_entry_t     q_wdata, q_head;

    assign complete          = rden_q & memValid1;
    assign still_outstanding = rden_q & ~memValid1;
    assign pop               = INSTR_VALID & INSTR_READY;
    // Data returning in DRAIN, or alongside a redirect, belongs to the abandoned path.
    assign push              = complete & (state_q == FETCH) & ~discard_q & ~REDIRECT &
                               (~q_full | pop);
    assign q_wdata           = '{pc: req_pc_q, instr: MEM_DOUT1};
    assign count_next        = REDIRECT ? '0 : q_count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (REDIRECT) begin
            fetch_pc_d = REDIRECT_PC;
        end else if (complete && state_q == FETCH) begin
            fetch_pc_d = req_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rden_q     <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (REDIRECT && still_outstanding) begin
                state_q   <= DRAIN;
                discard_q <= 1'b1;
            end else if (still_outstanding || (state_q == HALT && !REDIRECT)) begin
                // Hold the request stable, or stay halted until redirected.
            end else begin
                discard_q <= 1'b0;
                state_q   <= FETCH;
                rden_q    <= 1'b0;
                if (count_next < CNT_W'(QUEUE_DEPTH)) begin
                    if (pc_fetchable(fetch_pc_d, IMEM_LIMIT)) begin
                        rden_q   <= 1'b1;
                        req_pc_q <= fetch_pc_d;
                    end else begin
                        state_q <= HALT;
                    end
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (REDIRECT),
        .push  (push),
        .pop   (pop),
        .wdata (q_wdata),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign MEM_RDEN1   = rden_q;
    assign MEM_ADDR1   = req_pc_q[15:BYTE_OFFSET_W];
    assign INSTR_VALID = ~q_empty;
    assign INSTR       = q_head.instr;
    assign INSTR_PC    = q_head.pc;
    assign FAULT       = (state_q == HALT);

endmodule
